pattern_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for a merged pattern block: 15-bit stimulus in, 9-bit response out, single DFFARX1-style register stage.
- Resets the block under test, drives N pseudo-random vectors from an LFSR, and compacts the responses into a 16-bit MISR signature.
- Compares the signature with a golden value and reports pass/fail.
- Sits beside each generated pattern_merge instance as its test controller.

---
 rtl/pattern_bist_ctrl.sv | 149 ++++++++++++++
 tb/tb_pattern_bist_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pattern_bist_ctrl.sv
// BIST sequencer for a merged pattern block: resets it, drives LFSR vectors,
// compacts the responses into a 16-bit MISR and compares against a golden signature.
//
// state    | meaning
// S_IDLE   | waiting for start, block under test released
// S_RST    | 2-cycle reset pulse to the block under test
// S_RUN    | one LFSR vector per cycle, num_vec cycles
// S_DRAIN  | LAT cycles to let the last responses reach the MISR
// S_DONE   | one-cycle done pulse, pass result registered
module pattern_bist_ctrl #(
  parameter int              IN_W  = 15,
  parameter int              OUT_W = 9,
  parameter int              CNT_W = 16,
  parameter int              LAT   = 1,
  parameter logic [IN_W-1:0] SEED  = IN_W'(1)
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [15:0]      golden_sig,
  input  logic [OUT_W-1:0] dut_out,
  output logic [IN_W-1:0]  dut_in,
  output logic             dut_rst_n,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature
);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
  localparam int              TMR_W    = $clog2(LAT + 2);

  state_t           state;
  logic [IN_W-1:0]  lfsr;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] tmr;
  logic [LAT-1:0]   cap_sr;
  logic [15:0]      misr;

  logic [IN_W-1:0]  lfsr_nxt;
  logic [15:0]      misr_nxt;
  logic             vec_valid;
  logic             cap_en;
  logic             abort_ok;

  always_comb begin
    lfsr_nxt  = {lfsr[IN_W-2:0], lfsr[IN_W-1] ^ lfsr[IN_W-2]};
    vec_valid = (state == S_RUN);
    cap_en    = cap_sr[LAT-1];
    abort_ok  = abort && ((state == S_RST) || (state == S_RUN) || (state == S_DRAIN));
    misr_nxt  = misr;
    if (cap_en)
      misr_nxt = {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]} ^ 16'(dut_out);
  end

  assign signature = misr;

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      state     <= S_IDLE;
      lfsr      <= SEED_EFF;
      cnt       <= '0;
      tmr       <= '0;
      cap_sr    <= '0;
      misr      <= '0;
      dut_in    <= '0;
      dut_rst_n <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      cap_sr <= (cap_sr << 1) | LAT'(vec_valid);
      misr   <= misr_nxt;
      done   <= 1'b0;
      if (abort_ok) begin
        // Freeze the partial signature: drop responses still in flight.
        state     <= S_IDLE;
        cap_sr    <= '0;
        misr      <= misr;
        dut_in    <= '0;
        dut_rst_n <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_RST;
              cnt       <= num_vec;
              tmr       <= TMR_W'(1);
              misr      <= '0;
              pass      <= 1'b0;
              lfsr      <= SEED_EFF;
              busy      <= 1'b1;
              dut_rst_n <= 1'b0;
              dut_in    <= '0;
            end
          end
          S_RST: begin
            if (tmr == '0) begin
              dut_rst_n <= 1'b1;
              if (cnt == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
                pass  <= (misr_nxt == golden_sig);
              end else begin
                state  <= S_RUN;
                dut_in <= lfsr;
                lfsr   <= lfsr_nxt;
              end
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          S_RUN: begin
            cnt  <= cnt - 1'b1;
            lfsr <= lfsr_nxt;
            if (cnt == CNT_W'(1)) begin
              state  <= S_DRAIN;
              dut_in <= '0;
              tmr    <= TMR_W'(LAT - 1);
            end else begin
              dut_in <= lfsr;
            end
          end
          S_DRAIN: begin
            // The final capture lands on this edge, so compare the next MISR value.
            if (tmr == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= (misr_nxt == golden_sig);
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_bist_ctrl.sv
// Self-checking bench for pattern_bist_ctrl: table of runs plus abort, reset and
// start-while-busy sequences; applied vectors checked against a scoreboard queue.
module tb_pattern_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] num_vec, golden_sig;
  logic [8:0]  dut_out;
  logic [14:0] dut_in;
  logic        dut_rst_n, busy, done, pass;
  logic [15:0] signature;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          resp_mode = 0;
  logic [14:0] exp_q[$];

  pattern_bist_ctrl dut (
    .blif_clk_net(clk), .blif_reset_net(rst_n), .start(start), .abort(abort),
    .num_vec(num_vec), .golden_sig(golden_sig), .dut_out(dut_out), .dut_in(dut_in),
    .dut_rst_n(dut_rst_n), .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] resp_of(input logic [14:0] v, input int mode);
    if (mode == 1) return v[8:0] ^ v[14:6];
    if (mode == 2) return 9'h1A5;
    return 9'h000;
  endfunction

  // Stand-in for the block under test: one register stage, cleared by dut_rst_n.
  always @(posedge clk) begin
    if (!dut_rst_n) dut_out <= 9'h000;
    else            dut_out <= resp_of(dut_in, resp_mode);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst_n && dut_in != 15'h0) begin
      if (exp_q.size() == 0) check("unexpected_vec", {17'h0, dut_in}, 32'h0);
      else check("vec", {17'h0, dut_in}, {17'h0, exp_q.pop_front()});
    end
  end

  function automatic logic [15:0] model_sig(input int n, input int mode);
    logic [14:0] l;
    logic [15:0] m;
    l = 15'h0001;
    m = 16'h0;
    for (int i = 0; i < n; i++) begin
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {7'h0, resp_of(l, mode)};
      l = {l[13:0], l[14] ^ l[13]};
    end
    return m;
  endfunction

  task automatic push_vectors(input int n);
    logic [14:0] l;
    l = 15'h0001;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(l);
      l = {l[13:0], l[14] ^ l[13]};
    end
  endtask

  // Returns #1 after the edge that samples start, i.e. in cycle 1 of the run.
  task automatic do_start(input int n);
    @(posedge clk); #1;
    num_vec = 16'(n);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic run_full(input int n, input int mode, input logic [15:0] gold,
                          input logic [15:0] esig, input bit epass, input int inj);
    int cyc, dc0, exp_cyc;
    bit seen;
    resp_mode  = mode;
    golden_sig = gold;
    push_vectors(n);
    dc0     = done_cnt;
    exp_cyc = (n == 0) ? 3 : n + 4;
    do_start(n);
    cyc  = 1;
    seen = 0;
    while (!seen && cyc < n + 20) begin
      start = (cyc == inj);
      if (cyc == inj) num_vec = 16'd2;
      @(negedge clk);
      if (cyc <= 2) check("rst_pulse", {31'h0, dut_rst_n}, 32'h0);
      if (cyc == 3) check("rst_release", {31'h0, dut_rst_n}, 32'h1);
      if (n > 0 && cyc == n + 3) begin
        check("drain_in", {17'h0, dut_in}, 32'h0);
        check("drain_busy", {31'h0, busy}, 32'h1);
      end
      if (done) begin
        seen = 1;
        check("done_cycle", cyc, exp_cyc);
        check("signature", {16'h0, signature}, {16'h0, esig});
        check("pass", {31'h0, pass}, {31'h0, epass});
        check("busy_in_done", {31'h0, busy}, 32'h1);
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_pulse", {31'h0, done}, 32'h0);
    check("idle_busy", {31'h0, busy}, 32'h0);
    check("pass_sticky", {31'h0, pass}, {31'h0, epass});
    check("vec_count", exp_q.size(), 32'h0);
    check("done_once", done_cnt - dc0, 32'h1);
    exp_q.delete();
  endtask

  typedef struct {
    int          n;
    int          mode;
    logic [15:0] gold;
    logic [15:0] esig;
    bit          epass;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int dc0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    num_vec = 16'h0; golden_sig = 16'h0; resp_mode = 0;

    tbl.push_back('{3,  0, 16'h0000, 16'h0000, 1'b1});
    tbl.push_back('{1,  2, 16'h01A5, 16'h01A5, 1'b1});
    tbl.push_back('{1,  2, 16'h01A4, 16'h01A5, 1'b0});
    tbl.push_back('{0,  1, 16'h0000, 16'h0000, 1'b1});
    tbl.push_back('{0,  1, 16'h0005, 16'h0000, 1'b0});
    tbl.push_back('{3,  1, model_sig(3, 1), model_sig(3, 1), 1'b1});
    tbl.push_back('{17, 1, model_sig(17, 1) ^ 16'h0001, model_sig(17, 1), 1'b0});
    tbl.push_back('{40, 1, model_sig(40, 1), model_sig(40, 1), 1'b1});

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_dut_rst_n", {31'h0, dut_rst_n}, 32'h1);
    check("rst_dut_in", {17'h0, dut_in}, 32'h0);
    check("rst_sig", {16'h0, signature}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_pass", {31'h0, pass}, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_full(tbl[i].n, tbl[i].mode, tbl[i].gold, tbl[i].esig, tbl[i].epass, -1);

    // Abort in the second RUN cycle, then a clean rerun from the seed.
    resp_mode = 1;
    golden_sig = 16'h0;
    push_vectors(2);
    dc0 = done_cnt;
    do_start(10);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_rst_n", {31'h0, dut_rst_n}, 32'h1);
    check("abort_in", {17'h0, dut_in}, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - dc0, 32'h0);
    check("abort_pass", {31'h0, pass}, 32'h0);
    check("abort_vecs", exp_q.size(), 32'h0);
    exp_q.delete();
    run_full(10, 1, model_sig(10, 1), model_sig(10, 1), 1'b1, -1);

    // start pulsed mid-RUN with a different count must be ignored.
    run_full(6, 1, model_sig(6, 1), model_sig(6, 1), 1'b1, 4);

    // Asynchronous reset in the middle of a long run.
    resp_mode = 1;
    push_vectors(100);
    dc0 = done_cnt;
    do_start(100);
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_rst_n", {31'h0, dut_rst_n}, 32'h1);
    check("mid_rst_in", {17'h0, dut_in}, 32'h0);
    check("mid_rst_sig", {16'h0, signature}, 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (110) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt - dc0, 32'h0);
    check("mid_rst_idle", {31'h0, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
